// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the program-loading memory responder.
package mem_resp_pkg;

    // Loader / processor-run state machine encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } ldstate_t;

    // The memory-mapped output register sits at the all-ones address;
    // users slice this down to their own address width.
    localparam logic [31:0] MMIO_ADR_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_responder_byte_ram.sv
// Byte-wide RAM with one synchronous write port and one asynchronous
// read port. Contents are never reset.
module byte_ram #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**WIDTH];

    // Write port: single write per rising edge.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Zero-latency read so the processor can fetch in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: loads a program image through a byte stream while
// holding the processor in reset, then releases it and serves its
// loads and stores. Optional feature: define MEM_RESPONDER_MMIO_EN to map
// an output register (io_out / io_strobe) at the all-ones address.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             cpu_reset,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic [WIDTH-1:0] io_out,
    output logic             io_strobe
);

    localparam logic [WIDTH-1:0] MMIO_ADR = MMIO_ADR_ALL[WIDTH-1:0];

    ldstate_t         state;
    logic [WIDTH-1:0] ptr;

    logic             ld_acc;
    logic             cpu_wr;
    logic             mmio_hit;
    logic             ram_we;
    logic [WIDTH-1:0] ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    // Read data is always driven, so the strobe carries no information.
    logic             unused_memread;
    assign unused_memread = memread;

    // A restart in the same cycle as a byte wins; the byte is dropped.
    assign ld_acc = ld_ready && ld_valid && !ld_start;

`ifdef MEM_RESPONDER_MMIO_EN
    assign mmio_hit = (adr == MMIO_ADR);
`else
    assign mmio_hit = 1'b0;
`endif

    // Processor stores only count once the program is running.
    assign cpu_wr = (state == RUN) && memwrite && !mmio_hit;

    // Loader owns the write port during LOAD, processor otherwise.
    assign ram_we    = ld_acc || cpu_wr;
    assign ram_waddr = (state == LOAD) ? ptr     : adr;
    assign ram_wdata = (state == LOAD) ? ld_data : writedata;

    byte_ram #(.WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (adr),
        .rdata (ram_rdata)
    );

    assign memdata = mmio_hit ? io_out : ram_rdata;

    // Load/run FSM with registered cpu_reset and ld_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_start) begin
                        ptr <= '0;
                    end else if (ld_acc) begin
                        ptr <= ptr + 1'b1;
                        if (ld_last) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        ptr       <= '0;
                        ld_ready  <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ptr       <= '0;
                    cpu_reset <= 1'b1;
                    ld_ready  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_RESPONDER_MMIO_EN
    // Output register capture and one-cycle strobe on each store to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_out    <= '0;
            io_strobe <= 1'b0;
        end else begin
            io_strobe <= (state == RUN) && memwrite && mmio_hit;
            if ((state == RUN) && memwrite && mmio_hit)
                io_out <= writedata;
        end
    end
`else
    assign io_out    = '0;
    assign io_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WIDTH = 8).
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       memread;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic [7:0] memdata;
    logic       cpu_reset;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [7:0] io_out;
    logic       io_strobe;

    int n_chk = 0;
    int n_bad = 0;

    mem_responder #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .cpu_reset (cpu_reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .io_out    (io_out),
        .io_strobe (io_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        adr = a;
        #1;
        chk(tag, memdata, exp);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        tick();
        tick();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_ld_ready",  ld_ready,  0);
        chk("rst_io_out",    io_out,    0);
        chk("rst_io_strobe", io_strobe, 0);
        reset = 1'b0;

        // basic load of three bytes
        start_load();
        chk("load_ready", ld_ready, 1);
        chk("load_cpu_reset", cpu_reset, 1);
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        chk("load_mid_cpu_reset", cpu_reset, 1);
        load_byte(8'h33, 1'b1);
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_ld_ready", ld_ready, 0);
        rd_chk("img_1", 8'h01, 8'h22);
        rd_chk("img_0", 8'h00, 8'h11);
        rd_chk("img_2", 8'h02, 8'h33);

        // run-time stores: same-cycle read shows old, next cycle new
        cpu_wr(8'h40, 8'h3C);
        adr = 8'h40; writedata = 8'hA5; memwrite = 1'b1; memread = 1'b1;
        #1;
        chk("rw_same_old", memdata, 8'h3C);
        tick();
        memwrite = 1'b0; memread = 1'b0;
        #1;
        chk("rw_next_new", memdata, 8'hA5);

        // store to the all-ones address
        adr = 8'hFF; writedata = 8'h5C; memwrite = 1'b1;
        #1;
        chk("mmio_pre_strobe", io_strobe, 0);
        tick();
        memwrite = 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
        chk("mmio_strobe", io_strobe, 1);
        chk("mmio_io_out", io_out, 8'h5C);
        rd_chk("mmio_rd", 8'hFF, 8'h5C);
        tick();
        chk("mmio_strobe_end", io_strobe, 0);
        chk("mmio_io_hold", io_out, 8'h5C);
`else
        chk("nommio_io_out", io_out, 0);
        chk("nommio_strobe", io_strobe, 0);
        rd_chk("nommio_mem_ff", 8'hFF, 8'h5C);
        tick();
        chk("nommio_strobe2", io_strobe, 0);
`endif

        // RUN -> LOAD, stores ignored while loading
        start_load();
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_ready", ld_ready, 1);
        cpu_wr(8'h40, 8'hEE);
        rd_chk("load_wr_ignored", 8'h40, 8'hA5);

        // restart with a same-cycle byte: byte dropped, pointer back to 0
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        load_byte(8'h88, 1'b0);
        rd_chk("restart_ptr0", 8'h00, 8'h88);
        rd_chk("restart_keep1", 8'h01, 8'hBB);
        rd_chk("restart_drop", 8'h02, 8'h33);
        chk("restart_ready", ld_ready, 1);

        // reset in the middle of a load
        start_load();
        load_byte(8'hC1, 1'b0);
        load_byte(8'hC2, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_cpu_reset", cpu_reset, 1);
        chk("midrst_ready", ld_ready, 0);
        rd_chk("midrst_mem0", 8'h00, 8'hC1);
        rd_chk("midrst_mem1", 8'h01, 8'hC2);
        load_byte(8'h99, 1'b0);
        rd_chk("idle_byte_ignored", 8'h00, 8'hC1);
        cpu_wr(8'h40, 8'hEE);
        rd_chk("idle_wr_ignored", 8'h40, 8'hA5);
        chk("idle_ready", ld_ready, 0);

        // 257 bytes, pointer wraps
        start_load();
        for (int i = 0; i < 257; i++)
            load_byte(8'(i), 1'b0);
        chk("wrap_cpu_reset", cpu_reset, 1);
        rd_chk("wrap_mem0", 8'h00, 8'h00);
        rd_chk("wrap_mem1", 8'h01, 8'h01);
        rd_chk("wrap_mem80", 8'h80, 8'h80);
        load_byte(8'h5A, 1'b0);
        rd_chk("wrap_ptr1", 8'h01, 8'h5A);
        rd_chk("wrap_mem2", 8'h02, 8'h02);
        load_byte(8'h6B, 1'b1);
        chk("wrap_run", cpu_reset, 0);
        rd_chk("wrap_last", 8'h02, 8'h6B);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, default 8, data and address width; the memory holds 2**WIDTH bytes.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 memread  input  1  processor read strobe; informational only, because read data is always driven.
REQ-005 memwrite  input  1  processor write strobe.
REQ-006 adr  input  WIDTH  processor byte address.
REQ-007 writedata  input  WIDTH  processor store data.
REQ-008 memdata  output  WIDTH  read data returned to the processor.
REQ-009 cpu_reset  output  1  holds the processor in reset, active-high.
REQ-010 ld_start  input  1  begin a program load at address 0.
REQ-011 ld_valid  input  1  loader byte valid.
REQ-012 ld_data  input  WIDTH  loader byte.
REQ-013 ld_last  input  1  marks the final loader byte; qualified by ld_valid.
REQ-014 ld_ready  output  1  responder accepts loader bytes.
REQ-015 io_out  output  WIDTH  memory-mapped output register.
REQ-016 io_strobe  output  1  one-cycle pulse on each io_out update.

Function
REQ-017 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-018 IDLE SHALL go to LOAD on ld_start and otherwise hold.
REQ-019 LOAD SHALL go to RUN on the cycle after an accepted byte with ld_last=1.
REQ-020 RUN SHALL go to LOAD on ld_start.
REQ-021 Entering LOAD SHALL clear the load pointer to 0.
REQ-022 ld_start while in LOAD SHALL clear the pointer to 0 and SHALL take priority over a same-cycle byte, which is dropped.
REQ-023 cpu_reset SHALL be 1 in IDLE and LOAD and 0 in RUN; it deasserts the cycle after the last byte is accepted.
REQ-024 ld_ready SHALL be 1 only in LOAD; a byte is accepted when ld_valid=1 and ld_ready=1.
REQ-025 An accepted byte SHALL be written to mem[pointer], and the pointer SHALL then increment modulo 2**WIDTH, so 2**WIDTH-1 wraps to 0.
REQ-026 memdata SHALL equal mem[adr] combinationally in every state, with zero-cycle latency, as required for same-cycle fetch.
REQ-027 memwrite SHALL write writedata to mem[adr] at the clock edge, in RUN only; it is ignored in IDLE and LOAD.
REQ-028 When memread and memwrite are both 1, the write SHALL occur and memdata SHALL show the pre-write contents during that cycle.
REQ-029 A write followed by a read of the same address on the next cycle SHALL return the new data.

Reset
REQ-030 Reset SHALL force IDLE, pointer=0, cpu_reset=1, ld_ready=0, io_out=0 and io_strobe=0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset during LOAD SHALL abandon the load; bytes already written SHALL remain.

Configuration
REQ-033 With macro MEM_RESPONDER_MMIO_EN defined, a RUN-state memwrite to adr = all-ones SHALL load io_out with writedata and pulse io_strobe for the following cycle.
REQ-034 With MEM_RESPONDER_MMIO_EN defined, that write SHALL NOT update memory, and reads of the all-ones address SHALL return io_out.
REQ-035 Without MEM_RESPONDER_MMIO_EN, the all-ones address SHALL be ordinary memory, and io_out and io_strobe SHALL be tied to 0.

Structure
REQ-036 Package mem_resp_pkg SHALL hold the state enum ldstate_t {IDLE, LOAD, RUN} as 2 bits, plus the MMIO address constant.
REQ-037 Sub-module byte_ram SHALL provide one synchronous write port and one asynchronous read port, parameterised by WIDTH.
REQ-038 The loader write and the CPU write SHALL be muxed in front of byte_ram by state.

Verification
REQ-039 Reset, then ld_start, then bytes 0x11, 0x22 and 0x33 (ld_last on 0x33) -> mem[0..2] = 11,22,33, cpu_reset falls on the cycle after 0x33, and adr=1 reads 0x22.
REQ-040 In RUN, memwrite with adr=0x40 and writedata=0xA5, then adr=0x40 on the next cycle -> memdata=0xA5; a same-cycle read shows the old value.
REQ-041 In LOAD, 257 bytes of value (i mod 256) with no ld_last -> pointer wraps, mem[0]=0x00 (overwritten by byte 256), and cpu_reset stays 1.
REQ-042 In RUN with MMIO_EN, memwrite at adr=0xFF with 0x5C -> io_out=0x5C with a single io_strobe pulse, and a read of 0xFF returns 0x5C; without the macro, mem[0xFF]=0x5C and io_out=0.
REQ-043 ld_start with ld_valid and byte 0x77 in the same cycle during LOAD -> byte dropped and pointer=0.
REQ-044 Reset asserted mid-LOAD after 2 bytes -> IDLE, cpu_reset=1, ld_ready=0, and mem[0..1] retained.
